fixed_point_requantizer: RTL and testbench

Streaming narrowing converter that takes wide signed fixed-point results (filter accumulator / MAC products) and returns them to sample format. Uses round-half-up rounding and saturation instead of truncation with an overflow flag. It sits at the filter output and on the coefficient-update path. Input and output use valid/ready handshakes, and the block keeps a saturating count of clipped samples for software/debug.

---
 rtl/fixed_point_requantizer_if.sv | 26 ++
 rtl/fixed_point_requantizer.sv | 89 ++++++++
 tb/tb_fixed_point_requantizer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_point_requantizer_if.sv
// Valid/ready stream bundle for the requantizer: wide input side and narrow
// output side with its saturation flag.
interface fixed_point_requantizer_if #(
    parameter int DIN_WIDTH  = 32,
    parameter int DOUT_WIDTH = 16
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DIN_WIDTH-1:0]  s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DOUT_WIDTH-1:0] m_data;
    logic                  m_sat;

    // master: upstream producer plus downstream consumer (environment side)
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_sat
    );

    // slave: the requantizer itself
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_sat
    );
endinterface

// File: rtl/fixed_point_requantizer.sv
// Two-stage round-half-up / saturating narrowing converter with a global
// stall enable and a sticky count of clipped samples.
module fixed_point_requantizer #(
    parameter int DIN_WIDTH  = 32,
    parameter int DIN_FRAC   = 30,
    parameter int DOUT_WIDTH = 16,
    parameter int DOUT_FRAC  = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    fixed_point_requantizer_if.slave   stream,
    input  logic                       clr_count,
    output logic [15:0]                sat_count
);
    localparam int SHIFT = DIN_FRAC - DOUT_FRAC;
    localparam int SW    = DIN_WIDTH + 1;

    localparam logic signed [SW-1:0] MAXV = {{(SW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

    logic                   en;
    logic [SW-1:0]          round_const;
    logic [SW-1:0]          sum_next;
    logic                   s1_valid_reg;
    logic [SW-1:0]          s1_sum_reg;
    logic signed [SW-1:0]   q;
    logic [DOUT_WIDTH-1:0]  data_next;
    logic                   sat_next;
    logic                   m_valid_reg;
    logic [DOUT_WIDTH-1:0]  m_data_reg;
    logic                   m_sat_reg;
    logic [15:0]            sat_count_reg;

    assign en             = !m_valid_reg || stream.m_ready;
    assign stream.s_ready = en;
    assign stream.m_valid = m_valid_reg;
    assign stream.m_data  = m_data_reg;
    assign stream.m_sat   = m_sat_reg;
    assign sat_count      = sat_count_reg;

    // Half an output LSB; absent when no fractional bits are dropped.
    generate
        if (SHIFT > 0) begin : g_round
            assign round_const = SW'(1) << (SHIFT - 1);
        end else begin : g_noround
            assign round_const = '0;
        end
    endgenerate

    assign sum_next = {stream.s_data[DIN_WIDTH-1], stream.s_data} + round_const;
    assign q        = $signed(s1_sum_reg) >>> SHIFT;

    always_comb begin
        data_next = q[DOUT_WIDTH-1:0];
        sat_next  = 1'b0;
        if (q > MAXV) begin
            data_next = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
            sat_next  = 1'b1;
        end else if (q < MINV) begin
            data_next = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
            sat_next  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_sum_reg   <= '0;
            m_valid_reg  <= 1'b0;
            m_data_reg   <= '0;
            m_sat_reg    <= 1'b0;
        end else if (en) begin
            s1_valid_reg <= stream.s_valid;
            s1_sum_reg   <= sum_next;
            m_valid_reg  <= s1_valid_reg;
            m_data_reg   <= data_next;
            m_sat_reg    <= sat_next;
        end
    end

    // Counts saturated words actually handed downstream; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            sat_count_reg <= '0;
        end else if (m_valid_reg && stream.m_ready && m_sat_reg && (sat_count_reg != 16'hFFFF)) begin
            sat_count_reg <= sat_count_reg + 16'd1;
        end
    end
endmodule

// File: tb/tb_fixed_point_requantizer.sv
// Directed bench for fixed_point_requantizer (Q2.30 -> Q1.15) with an
// arithmetic reference model, scoreboard and per-cycle sat_count model.
module tb_fixed_point_requantizer;
    localparam int DIN_WIDTH  = 32;
    localparam int DIN_FRAC   = 30;
    localparam int DOUT_WIDTH = 16;
    localparam int DOUT_FRAC  = 15;
    localparam int SHIFT      = DIN_FRAC - DOUT_FRAC;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_count;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;
    int recv_count = 0;
    bit started = 0;

    logic [16:0] exp_q[$];
    int          model_cnt = 0;
    bit          stalled_prev = 0;
    logic [15:0] data_prev;
    logic        sat_prev;

    fixed_point_requantizer_if #(.DIN_WIDTH(DIN_WIDTH), .DOUT_WIDTH(DOUT_WIDTH)) bus ();

    fixed_point_requantizer #(
        .DIN_WIDTH(DIN_WIDTH), .DIN_FRAC(DIN_FRAC),
        .DOUT_WIDTH(DOUT_WIDTH), .DOUT_FRAC(DOUT_FRAC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stream(bus),
        .clr_count(clr_count),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    // Reference: floor((x + half LSB) / 2^SHIFT), then clip to the output range.
    function automatic logic [16:0] model(input logic [31:0] din);
        longint v, num, den, qv;
        logic   sat;
        v   = longint'($signed(din));
        den = longint'(1) << SHIFT;
        num = v + den / 2;
        if (num >= 0) qv = num / den;
        else          qv = -((-num + den - 1) / den);
        sat = 1'b0;
        if (qv > 32767)  begin qv = 32767;  sat = 1'b1; end
        if (qv < -32768) begin qv = -32768; sat = 1'b1; end
        return {sat, 16'(qv)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Compare process: everything sampled on the falling edge, i.e. the
    // values that the next rising edge will act upon.
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            exp_q.delete();
            model_cnt    = 0;
            stalled_prev = 0;
        end else if (started) begin
            check("sat_count_model", 32'(sat_count), 32'(model_cnt));
            if (stalled_prev) begin
                check("stall_valid", 32'(bus.m_valid), 32'd1);
                check("stall_data", 32'(bus.m_data), 32'(data_prev));
                check("stall_sat", 32'(bus.m_sat), 32'(sat_prev));
            end
            stalled_prev = bus.m_valid && !bus.m_ready;
            data_prev    = bus.m_data;
            sat_prev     = bus.m_sat;
            e = 17'd0;
            if (bus.m_valid && bus.m_ready) begin
                recv_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h with nothing pending", bus.m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", 32'(bus.m_data), 32'(e[15:0]));
                    check("sb_sat", 32'(bus.m_sat), 32'(e[16]));
                end
            end
            if (clr_count) model_cnt = 0;
            else if (e[16] && model_cnt != 65535) model_cnt++;
            if (bus.s_valid && bus.s_ready) exp_q.push_back(model(bus.s_data));
        end
    end

    task automatic directed(input string name, input logic [31:0] din,
                            input logic [15:0] exp_d, input logic exp_s);
        @(posedge clk); #1;
        bus.s_valid = 1'b1;
        bus.s_data  = din;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        check({name, "_lat1"}, 32'(bus.m_valid), 32'd0);
        @(posedge clk); #1;
        check({name, "_valid"}, 32'(bus.m_valid), 32'd1);
        check({name, "_data"}, 32'(bus.m_data), 32'(exp_d));
        check({name, "_sat"}, 32'(bus.m_sat), 32'(exp_s));
        $display("xact %s: in=%h out=%h sat=%b", name, din, bus.m_data, bus.m_sat);
    endtask

    function automatic logic [31:0] bp_word(input int i);
        return 32'h0000_8000 * i + 32'h0000_4000;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, acc_low, r0, cyc;
        logic [31:0] pattern;

        rst = 1'b1; clr_count = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        started = 1;
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        check("rst_m_sat", 32'(bus.m_sat), 32'd0);
        check("rst_sat_count", 32'(sat_count), 32'd0);
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);

        directed("nom_pos", 32'h2000_0000, 16'h4000, 1'b0);
        directed("nom_neg", 32'hC000_0000, 16'h8000, 1'b0);
        directed("rnd_up", 32'h0000_4000, 16'h0001, 1'b0);
        directed("rnd_down", 32'h0000_3FFF, 16'h0000, 1'b0);
        directed("rnd_neg_tie", 32'hFFFF_C000, 16'h0000, 1'b0);
        directed("rnd_neg", 32'hFFFF_BFFF, 16'hFFFF, 1'b0);
        directed("sat_pos", 32'h4000_0000, 16'h7FFF, 1'b1);
        directed("sat_carry", 32'h3FFF_C000, 16'h7FFF, 1'b1);
        directed("sat_neg", 32'h8000_0000, 16'h8000, 1'b1);
        @(posedge clk); #1;
        check("sat_count_3", 32'(sat_count), 32'd3);
        $display("xact sat_count: %0d", sat_count);

        // Backpressure: 5 cycles of m_ready low, then a fixed toggle pattern.
        repeat (3) @(posedge clk); #1;
        r0 = recv_count; sent = 0; acc_low = 0;
        pattern = 32'hB5A3_6C91;
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = bp_word(0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.s_ready) begin acc_low++; sent++; end
            @(posedge clk); #1;
            bus.s_data = bp_word(sent);
        end
        check("bp_accepted_low", 32'(acc_low), 32'd2);
        check("bp_s_ready_low", 32'(bus.s_ready), 32'd0);
        cyc = 0;
        while ((sent < 10 || recv_count - r0 < 10) && cyc < 300) begin
            bus.m_ready = pattern[cyc % 32];
            bus.s_valid = (sent < 10);
            bus.s_data  = bp_word(sent);
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        check("bp_received", 32'(recv_count - r0), 32'd10);
        check("bp_pending", 32'(exp_q.size()), 32'd0);
        $display("xact backpressure: sent=%0d received=%0d cycles=%0d", sent, recv_count - r0, cyc);

        // Saturating counter: 65540 clipped transfers must stick at 0xFFFF.
        @(posedge clk); #1 clr_count = 1'b1;
        @(posedge clk); #1 clr_count = 1'b0;
        check("clr_count", 32'(sat_count), 32'd0);
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h4000_0000;
        repeat (65540) @(posedge clk);
        #1 bus.s_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("sat_count_stick", 32'(sat_count), 32'h0000_FFFF);
        $display("xact sat_count_stick: %h", sat_count);

        // Clear coinciding with a saturated transfer.
        @(posedge clk); #1;
        bus.s_valid = 1'b1; bus.s_data = 32'h8000_0000;
        @(posedge clk); #1 bus.s_valid = 1'b0;
        @(posedge clk); #1;
        check("clr_coinc_valid", 32'(bus.m_valid), 32'd1);
        clr_count = 1'b1;
        @(posedge clk); #1 clr_count = 1'b0;
        check("clr_coinc_count", 32'(sat_count), 32'd0);
        $display("xact clr_coincident: sat_count=%0d", sat_count);

        // One counted transfer, then reset with two words held in flight.
        directed("pre_rst_sat", 32'h4000_0000, 16'h7FFF, 1'b1);
        @(posedge clk); #1;
        check("pre_rst_count", 32'(sat_count), 32'd1);
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 32'h4000_0000;
        @(posedge clk); #1 bus.s_data = 32'h1234_5678;
        @(posedge clk); #1;
        check("inflight_stall", 32'(bus.s_ready), 32'd0);
        r0 = recv_count;
        rst = 1'b1; bus.s_valid = 1'b0; bus.m_ready = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("mid_rst_valid", 32'(bus.m_valid), 32'd0);
        check("mid_rst_data", 32'(bus.m_data), 32'd0);
        check("mid_rst_count", 32'(sat_count), 32'd0);
        repeat (6) @(posedge clk); #1;
        check("mid_rst_no_output", 32'(recv_count - r0), 32'd0);
        $display("xact mid_reset: outputs_after=%0d", recv_count - r0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
